// File: rtl/nes_pad_reader.sv
//------------------------------------------------------------------------------
// nes_pad_reader : polls CHANNELS NES pads over a shared latch/clock pair and
//                  reports button state, press/repeat pulses and a combo reset.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nes_pad_reader #(
    parameter int CHANNELS     = 2,
    parameter int POLL_CYCLES  = 833333,
    parameter int HALF_BIT     = 300,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 6,
    parameter int COMBO_POLLS  = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   nes_data,
    output logic                  nes_latch,
    output logic                  nes_clk,
    output logic [8*CHANNELS-1:0] buttons,
    output logic [8*CHANNELS-1:0] press,
    output logic                  frame_valid,
    output logic                  nes_reset
);

    localparam int POLL_W  = $clog2(POLL_CYCLES + 1);
    localparam int PH_W    = $clog2(2 * HALF_BIT + 1);
    localparam int HOLD_W  = $clog2(REPEAT_DELAY + 1);
    localparam int COMBO_W = $clog2(COMBO_POLLS + 1);
    localparam int WRAP_I  = (REPEAT_DELAY > REPEAT_RATE) ? (REPEAT_DELAY - REPEAT_RATE) : 0;

    localparam logic [POLL_W-1:0]  c_POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
    localparam logic [PH_W-1:0]    c_LATCH_LAST = PH_W'(2 * HALF_BIT - 1);
    localparam logic [PH_W-1:0]    c_HALF_LAST  = PH_W'(HALF_BIT - 1);
    localparam logic [HOLD_W-1:0]  c_REP_DELAY  = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0]  c_REP_WRAP   = HOLD_W'(WRAP_I);
    localparam logic [COMBO_W-1:0] c_COMBO      = COMBO_W'(COMBO_POLLS);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LATCH  = 3'd1;
    localparam logic [2:0] c_ST_HI     = 3'd2;
    localparam logic [2:0] c_ST_LO     = 3'd3;
    localparam logic [2:0] c_ST_UPDATE = 3'd4;

    logic [POLL_W-1:0]             r_poll;
    logic [2:0]                    r_state;
    logic [PH_W-1:0]               r_ph;
    logic [2:0]                    r_bit;
    logic [CHANNELS-1:0][7:0]      r_shift;
    logic                          r_frame_valid;
    logic                          r_nes_reset;
    logic                          w_tick;
    logic                          w_sample;
    logic                          w_update;
    logic [CHANNELS-1:0]           w_fire;

    assign w_tick   = (r_poll == c_POLL_LAST);
    assign w_update = (r_state == c_ST_UPDATE);
    assign w_sample = ((r_state == c_ST_LATCH) && (r_ph == c_LATCH_LAST)) ||
                      ((r_state == c_ST_LO) && (r_ph == c_HALF_LAST));

    assign nes_latch   = (r_state == c_ST_LATCH);
    assign nes_clk     = (r_state == c_ST_HI);
    assign frame_valid = r_frame_valid;
    assign nes_reset   = r_nes_reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_poll <= '0;
        end else begin
            r_poll <= w_tick ? '0 : r_poll + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_ph    <= '0;
            r_bit   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_ph <= '0;
                    if (w_tick) r_state <= c_ST_LATCH;
                end
                c_ST_LATCH: begin
                    if (r_ph == c_LATCH_LAST) begin
                        r_ph    <= '0;
                        r_state <= c_ST_HI;
                    end else begin
                        r_ph <= r_ph + 1'b1;
                    end
                end
                c_ST_HI: begin
                    if (r_ph == c_HALF_LAST) begin
                        r_ph    <= '0;
                        r_state <= c_ST_LO;
                    end else begin
                        r_ph <= r_ph + 1'b1;
                    end
                end
                c_ST_LO: begin
                    if (r_ph == c_HALF_LAST) begin
                        r_ph <= '0;
                        if (r_bit == 3'd6) begin
                            r_bit   <= '0;
                            r_state <= c_ST_UPDATE;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_state <= c_ST_HI;
                        end
                    end else begin
                        r_ph <= r_ph + 1'b1;
                    end
                end
                default: begin
                    r_ph    <= '0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Bits arrive LSB first, so shift in at the top; after 8 samples bit0 sits at [0].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
        end else if (w_sample) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_shift[c] <= {nes_data[c], r_shift[c][7:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_valid <= 1'b0;
            r_nes_reset   <= 1'b0;
        end else begin
            r_frame_valid <= w_update;
            r_nes_reset   <= w_update && (|w_fire);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [7:0]         w_new;
        logic [7:0]         w_rep;
        logic               w_valid;
        logic               w_combo;
        logic [COMBO_W-1:0] w_cinc;
        logic [7:0]         r_btn;
        logic [7:0]         r_press;
        logic [COMBO_W-1:0] r_combo;
        logic               r_disarm;

        // An all-zero raw frame reads as every button pressed, which a real pad cannot produce.
        assign w_new   = ~r_shift[c];
        assign w_valid = (r_shift[c] != 8'h00);
        assign w_combo = w_new[2] && w_new[3];
        assign w_cinc  = r_combo + 1'b1;
        assign w_fire[c] = w_valid && w_combo && !r_disarm && (w_cinc == c_COMBO);

        assign buttons[8*c +: 8] = r_btn;
        assign press[8*c +: 8]   = r_press;

        for (genvar b = 0; b < 8; b++) begin : g_bit
            if ((REPEAT_EN != 0) && (b >= 4)) begin : g_rep
                logic [HOLD_W-1:0] r_hold;
                logic [HOLD_W-1:0] w_inc;

                assign w_inc    = r_hold + 1'b1;
                assign w_rep[b] = w_new[b] && (w_inc == c_REP_DELAY);

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        r_hold <= '0;
                    end else if (w_update && w_valid) begin
                        if (!w_new[b])                r_hold <= '0;
                        else if (w_inc == c_REP_DELAY) r_hold <= c_REP_WRAP;
                        else                          r_hold <= w_inc;
                    end
                end
            end else begin : g_norep
                assign w_rep[b] = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_btn    <= '0;
                r_press  <= '0;
                r_combo  <= '0;
                r_disarm <= 1'b0;
            end else if (w_update && w_valid) begin
                r_btn   <= w_new;
                r_press <= (w_new & ~r_btn) | w_rep;
                if (!w_combo) begin
                    r_combo  <= '0;
                    r_disarm <= 1'b0;
                end else begin
                    if (r_combo != c_COMBO) r_combo <= w_cinc;
                    if (w_fire[c])          r_disarm <= 1'b1;
                end
            end else begin
                r_press <= '0;
            end
        end
    end

endmodule

`default_nettype wire
